// File: rtl/sobel_edge_filter_if.sv
// Pixel-in / edge-out stream bundle for the Sobel filter; no backpressure path.
// master = upstream gray source and result consumer, slave = the filter.
interface sobel_edge_filter_if;
  logic       start;
  logic       pix_valid;
  logic [7:0] gray_color;
  logic       res_valid;
  logic [7:0] edge_color;
  logic       done;

  modport master (
    output start, pix_valid, gray_color,
    input  res_valid, edge_color, done
  );

  modport slave (
    input  start, pix_valid, gray_color,
    output res_valid, edge_color, done
  );
endinterface

// File: rtl/sobel_edge_filter.sv
// Streaming 3x3 Sobel, saturated |Gx|+|Gy| per interior pixel; 2-cycle latency.
// No backpressure: one pixel per clock accepted, gaps in pix_valid stall the window.
module sobel_edge_filter #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  sobel_edge_filter_if.slave bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic          accept, last_pix, win_out;
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb2 [IMG_WIDTH];
  logic [7:0]    win [3][3];
  logic          s1_vld, s1_last;
  logic          res_vld_q, done_q;
  logic [7:0]    edge_q;
  logic [10:0]   px, nx, py, ny, gx, gy, ax, ay, mag;
  logic [7:0]    mag_sat;

  // A start pulse re-bases the position so a same-cycle pixel lands at (0,0).
  assign cur_col  = bus.start ? '0 : col;
  assign cur_row  = bus.start ? '0 : row;
  assign accept   = bus.pix_valid && (bus.start || (state == RUN));
  assign last_pix = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
  assign win_out  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (accept && last_pix) state_nxt = DONE;
        DONE:    if (done_q) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end else if (bus.start) begin
      col <= '0;
      row <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb2[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= bus.gray_color;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win     <= '{default: '0};
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld  <= accept && win_out;
      s1_last <= accept && last_pix;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2[cur_col];
        win[1][2] <= lb1[cur_col];
        win[2][2] <= bus.gray_color;
      end
    end
  end

  always_comb begin
    px  = {3'b000, win[0][2]} + {2'b00, win[1][2], 1'b0} + {3'b000, win[2][2]};
    nx  = {3'b000, win[0][0]} + {2'b00, win[1][0], 1'b0} + {3'b000, win[2][0]};
    py  = {3'b000, win[2][0]} + {2'b00, win[2][1], 1'b0} + {3'b000, win[2][2]};
    ny  = {3'b000, win[0][0]} + {2'b00, win[0][1], 1'b0} + {3'b000, win[0][2]};
    gx  = px - nx;
    gy  = py - ny;
    ax  = gx[10] ? (~gx + 11'd1) : gx;
    ay  = gy[10] ? (~gy + 11'd1) : gy;
    mag = ax + ay;
    mag_sat = (mag > 11'd255) ? 8'hFF : mag[7:0];
  end

  // A start in flight discards whatever stage 1 was about to publish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_vld_q <= 1'b0;
      done_q    <= 1'b0;
      edge_q    <= '0;
    end else begin
      res_vld_q <= s1_vld && !bus.start;
      done_q    <= s1_vld && s1_last && !bus.start;
      if (s1_vld) edge_q <= mag_sat;
    end
  end

  assign bus.res_valid  = res_vld_q;
  assign bus.edge_color = edge_q;
  assign bus.done       = done_q;
endmodule
